seg7_scan_reader: RTL and testbench

//  Reader side of the multiplexed 7-segment display interface: it snoops a scanned display bus
//  (active-low segment lines plus active-low digit enables) and recovers the hex digit shown on each position.

---
 rtl/seg7_scan_if.sv | 27 ++
 rtl/seg7_scan_reader.sv | 167 ++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Scanned 7-segment display bus plus the reader's recovered-digit outputs.
//   master: drives seg_n/an_n/clr, observes the reader outputs (board wrapper / bench)
//   slave : the reader itself
interface seg7_scan_if #(
  parameter int unsigned NDIG = 8
);
  logic [6:0]        seg_n;       // segment lines, active-low, bit0=a .. bit6=g
  logic [NDIG-1:0]   an_n;        // digit enables, active-low
  logic              clr;         // clear sticky flags and frame-seen mask
  logic [4*NDIG-1:0] value;       // recovered nibbles, digit i at [4i+3:4i]
  logic [NDIG-1:0]   digit_vld;   // last capture of digit i was a legal glyph
  logic              sample_stb;  // one pulse per capture
  logic [3:0]        sample_idx;  // digit index of the capture
  logic              frame_done;  // every digit captured since last pulse/clr
  logic              bad_pat;     // sticky illegal glyph
  logic              bad_sel;     // sticky multi-digit select

  modport master (
    output seg_n, an_n, clr,
    input  value, digit_vld, sample_stb, sample_idx, frame_done, bad_pat, bad_sel
  );

  modport slave (
    input  seg_n, an_n, clr,
    output value, digit_vld, sample_stb, sample_idx, frame_done, bad_pat, bad_sel
  );
endinterface

// File: rtl/seg7_scan_reader.sv
// Snoops a multiplexed 7-segment bus and recovers the hex digit on each position.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : seg7_scan_if.slave (seg_n/an_n/clr in; value, digit_vld, sample_stb,
//              sample_idx, frame_done, bad_pat, bad_sel out; all outputs registered)
module seg7_scan_reader #(
  parameter int unsigned NDIG   = 8,
  parameter int unsigned SETTLE = 4
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [6:0]        prev_seg;
  logic [NDIG-1:0]   prev_an;
  logic [CW-1:0]     run_cnt, run_cnt_nxt;
  logic [NDIG-1:0]   seen;

  logic [4*NDIG-1:0] value_q;
  logic [NDIG-1:0]   digit_vld_q;
  logic              stb_q;
  logic [3:0]        idx_q;
  logic              frame_done_q;
  logic              bad_pat_q;
  logic              bad_sel_q;

  logic [NDIG-1:0]   sel_c;
  logic              onehot_c;
  logic              multi_c;
  logic              match_c;
  logic              cap_c;
  logic [3:0]        cap_idx_c;
  logic [4:0]        dec_c;
  logic              blank_c;
  logic [NDIG-1:0]   cap_bit_c;

  // Glyph -> {legal, nibble}
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40: r = 5'h10;  7'h79: r = 5'h11;  7'h24: r = 5'h12;  7'h30: r = 5'h13;
      7'h19: r = 5'h14;  7'h12: r = 5'h15;  7'h02: r = 5'h16;  7'h78: r = 5'h17;
      7'h00: r = 5'h18;  7'h10: r = 5'h19;  7'h08: r = 5'h1A;  7'h03: r = 5'h1B;
      7'h46: r = 5'h1C;  7'h21: r = 5'h1D;  7'h06: r = 5'h1E;  7'h0E: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Index of the low enable bit (only meaningful for a one-hot select)
  function automatic logic [3:0] low_index(input logic [NDIG-1:0] an);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (!an[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Select classification and run counter (saturating at SETTLE)
  always_comb begin
    sel_c       = ~bus.an_n;
    onehot_c    = (sel_c != '0) && ((sel_c & (sel_c - NDIG'(1))) == '0);
    multi_c     = (sel_c != '0) && !onehot_c;
    match_c     = (bus.seg_n == prev_seg) && (bus.an_n == prev_an);
    run_cnt_nxt = CW'(1);
    if (match_c) begin
      run_cnt_nxt = (run_cnt >= SETTLE_C) ? SETTLE_C : run_cnt + CW'(1);
    end
  end

  // Capture decode works on the registered (settled) bus copy
  always_comb begin
    cap_c     = (state == ST_CAPTURE);
    cap_idx_c = low_index(prev_an);
    dec_c     = decode(prev_seg);
    blank_c   = (prev_seg == 7'h7F);
    cap_bit_c = cap_c ? (NDIG'(1) << cap_idx_c) : '0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (onehot_c) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!onehot_c)                    state_nxt = ST_IDLE;
        else if (run_cnt_nxt == SETTLE_C) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE, ST_HOLD: begin
        if (!match_c)         state_nxt = onehot_c ? ST_SETTLE : ST_IDLE;
        else                  state_nxt = ST_HOLD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus pipeline, shadow registers, frame tracking and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_seg     <= '0;
      prev_an      <= '0;
      run_cnt      <= '0;
      seen         <= '0;
      value_q      <= '0;
      digit_vld_q  <= '0;
      stb_q        <= 1'b0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      bad_pat_q    <= 1'b0;
      bad_sel_q    <= 1'b0;
    end else begin
      prev_seg     <= bus.seg_n;
      prev_an      <= bus.an_n;
      run_cnt      <= run_cnt_nxt;
      stb_q        <= cap_c;
      frame_done_q <= &seen;

      if (cap_c) begin
        idx_q <= cap_idx_c;
        for (int i = 0; i < int'(NDIG); i++) begin
          if (cap_idx_c == 4'(i)) begin
            digit_vld_q[i] <= dec_c[4];
            if (dec_c[4]) value_q[4*i +: 4] <= dec_c[3:0];
          end
        end
      end

      // A full mask clears; a capture in that same cycle starts the next frame
      if (bus.clr)    seen <= '0;
      else if (&seen) seen <= cap_bit_c;
      else            seen <= seen | cap_bit_c;

      if (bus.clr)                                 bad_pat_q <= 1'b0;
      else if (cap_c && !dec_c[4] && !blank_c)     bad_pat_q <= 1'b1;

      if (bus.clr)                                 bad_sel_q <= 1'b0;
      else if (multi_c && run_cnt_nxt == SETTLE_C) bad_sel_q <= 1'b1;
    end
  end

  assign bus.value      = value_q;
  assign bus.digit_vld  = digit_vld_q;
  assign bus.sample_stb = stb_q;
  assign bus.sample_idx = idx_q;
  assign bus.frame_done = frame_done_q;
  assign bus.bad_pat    = bad_pat_q;
  assign bus.bad_sel    = bad_sel_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (NDIG=8, SETTLE=4).
module tb_seg7_scan_reader;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   stb_cnt = 0;
  int   fd_cnt  = 0;
  int   base;

  seg7_scan_if #(.NDIG(8)) bus ();

  seg7_scan_reader #(.NDIG(8), .SETTLE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.sample_stb) stb_cnt++;
    if (bus.frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance n clocks, landing 1 time unit after the last edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] d, input logic [6:0] s);
    logic [7:0] one;
    one        = 8'h01;
    bus.an_n   = ~(one << d);
    bus.seg_n  = s;
  endtask

  task automatic show(input logic [2:0] d, input logic [6:0] s, input int n);
    drive(d, s);
    step(n);
  endtask

  logic [6:0] glyph [8];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    glyph[0] = 7'h40; glyph[1] = 7'h79; glyph[2] = 7'h24; glyph[3] = 7'h30;
    glyph[4] = 7'h19; glyph[5] = 7'h12; glyph[6] = 7'h02; glyph[7] = 7'h78;

    // Reset with the bus toggling
    rst = 1'b1; bus.clr = 1'b0; bus.seg_n = 7'h7F; bus.an_n = 8'hFF;
    #1;
    show(3'd0, 7'h40, 1);
    show(3'd2, 7'h30, 1);
    chk("rst_value", bus.value, 32'h0);
    chk("rst_vld",   32'(bus.digit_vld), 32'h0);
    chk("rst_stb",   32'(bus.sample_stb), 32'h0);
    chk("rst_idx",   32'(bus.sample_idx), 32'h0);
    chk("rst_fd",    32'(bus.frame_done), 32'h0);
    chk("rst_flags", {30'h0, bus.bad_pat, bus.bad_sel}, 32'h0);
    rst = 1'b0; bus.an_n = 8'hFF; bus.seg_n = 7'h7F;
    base = stb_cnt;
    step(2);
    chk("rst_no_stb", 32'(stb_cnt - base), 32'h0);

    // Single capture: stable from cycle t, strobe in t+5
    drive(3'd2, 7'h30);
    step(4);
    chk("single_early", 32'(bus.sample_stb), 32'h0);
    step(1);
    chk("single_stb",  32'(bus.sample_stb), 32'h1);
    chk("single_idx",  32'(bus.sample_idx), 32'h2);
    chk("single_val",  32'(bus.value[11:8]), 32'h3);
    chk("single_vld",  32'(bus.digit_vld[2]), 32'h1);
    step(1);
    chk("single_pulse", 32'(bus.sample_stb), 32'h0);
    step(3);

    // Glitch restarts the settle count
    base = stb_cnt;
    show(3'd0, 7'h12, 3);
    show(3'd0, 7'h00, 1);
    show(3'd0, 7'h12, 6);
    chk("glitch_stbs", 32'(stb_cnt - base), 32'h1);
    chk("glitch_val",  32'(bus.value[3:0]), 32'h5);

    // Full scan 0..7
    bus.clr = 1'b1; step(1); bus.clr = 1'b0;
    base = fd_cnt;
    for (int d = 0; d < 7; d++) show(3'(d), glyph[d], 6);
    show(3'd7, glyph[7], 5);
    chk("scan_idx7", 32'(bus.sample_idx), 32'h7);
    chk("scan_fd_early", 32'(bus.frame_done), 32'h0);
    step(1);
    chk("scan_fd", 32'(bus.frame_done), 32'h1);
    chk("scan_value", bus.value, 32'h76543210);
    chk("scan_vld", 32'(bus.digit_vld), 32'hFF);
    step(1);
    chk("scan_fd_count", 32'(fd_cnt - base), 32'h1);

    // Illegal glyph, then a double select
    show(3'd1, 7'h55, 6);
    chk("badpat_flag", 32'(bus.bad_pat), 32'h1);
    chk("badpat_vld",  32'(bus.digit_vld[1]), 32'h0);
    chk("badpat_keep", 32'(bus.value[7:4]), 32'h1);
    base = stb_cnt;
    bus.an_n = 8'hFC; bus.seg_n = 7'h40;
    step(5);
    chk("badsel_flag", 32'(bus.bad_sel), 32'h1);
    chk("badsel_nostb", 32'(stb_cnt - base), 32'h0);
    bus.an_n = 8'hFF; bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    chk("clr_flags", {30'h0, bus.bad_pat, bus.bad_sel}, 32'h0);

    // Blank glyph
    show(3'd0, 7'h7F, 6);
    chk("blank_vld",  32'(bus.digit_vld[0]), 32'h0);
    chk("blank_flag", 32'(bus.bad_pat), 32'h0);
    chk("blank_keep", 32'(bus.value[3:0]), 32'h0);

    // clr landing on a capture: value written, mask not recorded
    drive(3'd3, 7'h02);
    step(4);
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    chk("clrcap_stb", 32'(bus.sample_stb), 32'h1);
    chk("clrcap_val", 32'(bus.value[15:12]), 32'h6);
    chk("clrcap_vld", 32'(bus.digit_vld[3]), 32'h1);
    step(1);
    base = fd_cnt;
    for (int d = 0; d < 8; d++) if (d != 3) show(3'(d), glyph[d], 6);
    chk("clrcap_nofd", 32'(fd_cnt - base), 32'h0);
    show(3'd3, glyph[3], 7);
    chk("clrcap_fd", 32'(fd_cnt - base), 32'h1);

    // clr on an illegal-glyph capture drops the error
    drive(3'd5, 7'h55);
    step(4);
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    chk("clrcap_err", 32'(bus.bad_pat), 32'h0);
    step(1);

    // Reset while in CAPTURE
    drive(3'd4, 7'h19);
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0; bus.an_n = 8'hFF;
    chk("rstcap_stb", 32'(bus.sample_stb), 32'h0);
    chk("rstcap_val", bus.value, 32'h0);
    chk("rstcap_vld", 32'(bus.digit_vld), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
